// File: rtl/serial_link_pkg.sv
// serial_link_pkg
//   Shared definitions for the sen/sd serial address/data link.
//   - default frame-field widths and parity option
//   - frame_w(): number of bits on the wire for one frame
//   - rx_state_e: receiver FSM states
//   - even_parity(): XOR of all bits. The transmitter uses it to build the
//     trailing parity bit, and the receiver uses it to check the whole frame,
//     which must XOR to 0.
package serial_link_pkg;

  localparam int ADDR_W_DEF    = 3;
  localparam int DATA_W_DEF    = 18;
  localparam int PARITY_EN_DEF = 0;
  localparam int PAR_MAX_W     = 64;  // widest frame even_parity() accepts

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_OVERRUN = 2'd2,
    ST_DONE    = 2'd3
  } rx_state_e;

  function automatic int frame_w(input int addr_w, input int data_w, input int parity_en);
    return addr_w + data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/serial_frame_shift.sv
// serial_frame_shift
//   Frame deserialiser. It holds the MSB-first shift register and the bit
//   counter, and checks the frame length and parity.
// Ports
//   clk, rst      clock, async active-low reset
//   i_load        first bit of a new frame: restart the count at 1
//   i_shift       further frame bit: shift it in and count it
//   i_sd          serial data bit
//   o_full        exactly FRAME_W bits are held
//   o_frame_ok    held bits form a complete frame with good parity
//   o_frame_bad   complement of o_frame_ok (short frame or bad parity)
//   o_addr/o_data address and data fields of the held frame
module serial_frame_shift
  import serial_link_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PARITY_EN = PARITY_EN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic              i_sd,
  output logic              o_full,
  output logic              o_frame_ok,
  output logic              o_frame_bad,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W, PARITY_EN);
  localparam int CW      = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0] r_sr;
  logic [CW-1:0]      r_cnt;
  logic               w_par_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= {{(FRAME_W-1){1'b0}}, i_sd};
      r_cnt <= CW'(1);
    end else if (i_shift) begin
      r_sr  <= {r_sr[FRAME_W-2:0], i_sd};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The whole frame, parity bit included, must XOR to zero.
  assign w_par_ok    = (PARITY_EN == 0) || (even_parity(PAR_MAX_W'(r_sr)) == 1'b0);
  assign o_full      = (r_cnt == CW'(FRAME_W));
  assign o_frame_ok  = o_full && w_par_ok;
  assign o_frame_bad = !o_frame_ok;
  assign o_addr      = r_sr[FRAME_W-1 -: ADDR_W];
  assign o_data      = r_sr[FRAME_W-1-ADDR_W -: DATA_W];

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receives sen/sd address/data frames and writes good frames into a
//   single-port synchronous RAM. Raises S2_done after NUM_FRAMES writes.
// Ports
//   clk, rst        clock, async active-low reset
//   sen, sd         serial link (sen=0: sd carries a frame bit)
//   RB2_RW          RAM write enable, active low, one cycle per good frame
//   RB2_A, RB2_D    RAM address / write data
//   RB2_Q           RAM read data (unused)
//   S2_done         sticky completion flag
//   good_cnt        frames written (saturating)
//   err_cnt         frames rejected (saturating)
//   frame_err       one-cycle pulse per rejected frame
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_FRAMES = 8,
  parameter int PARITY_EN  = PARITY_EN_DEF,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q,
  output logic              S2_done,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              frame_err
);

  localparam logic [31:0] NUM_F = 32'(NUM_FRAMES);

  rx_state_e         r_state, w_next;
  logic              r_armed;
  logic              r_rw, r_done, r_ferr;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [CNT_W-1:0]  r_good, r_err;

  logic              w_load, w_shift, w_accept, w_reject, w_last;
  logic              w_full, w_frame_ok, w_frame_bad;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_unused_q;

  assign w_unused_q = ^RB2_Q;

  serial_frame_shift #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .PARITY_EN(PARITY_EN)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_sd       (sd),
    .o_full     (w_full),
    .o_frame_ok (w_frame_ok),
    .o_frame_bad(w_frame_bad),
    .o_addr     (w_addr),
    .o_data     (w_data)
  );

  // This accept brings the good count to NUM_FRAMES.
  assign w_last = (32'(r_good) + 32'd1) == NUM_F;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state. r_armed blocks a frame from starting until sen has been
  // seen high after reset, so the tail of a frame cut by reset is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (r_armed && !sen) w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (!sen) begin
          if (w_full) w_next = ST_OVERRUN;
        end else if (w_frame_ok && w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_OVERRUN: if (sen) w_next = ST_IDLE;
      ST_DONE:    w_next = ST_DONE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Output decode. Accept and reject are mutually exclusive, so a
  // write and frame_err never occur in the same cycle.
  always_comb begin
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      ST_IDLE:  w_load = r_armed && !sen;
      ST_SHIFT: begin
        w_shift  = !sen && !w_full;
        w_accept = sen && w_frame_ok;
        w_reject = (sen && w_frame_bad) || (!sen && w_full);
      end
      default: ;
    endcase
  end

  // RAM write register, counters and completion flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed <= 1'b0;
      r_rw    <= 1'b1;
      r_a     <= '0;
      r_d     <= '0;
      r_ferr  <= 1'b0;
      r_good  <= '0;
      r_err   <= '0;
      r_done  <= 1'b0;
    end else begin
      if (sen) r_armed <= 1'b1;
      r_rw   <= !w_accept;
      r_ferr <= w_reject;
      if (w_accept) begin
        r_a <= w_addr;
        r_d <= w_data;
        if (r_good != '1) r_good <= r_good + 1'b1;
      end
      if (w_reject && (r_err != '1)) r_err <= r_err + 1'b1;
      // Set once the final write has been presented to the RAM.
      if ((r_state == ST_DONE) && !r_rw) r_done <= 1'b1;
    end
  end

  assign RB2_RW    = r_rw;
  assign RB2_A     = r_a;
  assign RB2_D     = r_d;
  assign S2_done   = r_done;
  assign good_cnt  = r_good;
  assign err_cnt   = r_err;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Three receivers share one clock:
//     unit 0: defaults (3/18 bits, 8 frames, no parity)
//     unit 1: PARITY_EN=1
//     unit 2: ADDR_W=5, DATA_W=8, NUM_FRAMES=32
//   A table of frame records drives the units. Every good frame pushes its
//   expected RAM write to a queue, and a monitor pops the queue whenever a
//   DUT pulls RB2_RW low.
module tb_serial_frame_rx;

  localparam int NU = 3;

  typedef struct {
    int          u;
    bit          pre_rst;
    int          nbits;
    logic [4:0]  a;
    logic [17:0] d;
    bit          flip;     // send the wrong parity bit
  } rec_t;

  typedef struct {
    int          u;
    logic [4:0]  a;
    logic [17:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [NU];
  logic sen   [NU];
  logic sd    [NU];

  logic        rw_m   [NU];
  logic [4:0]  a_m    [NU];
  logic [17:0] d_m    [NU];
  logic        done_m [NU];
  logic        ferr_m [NU];
  logic [15:0] good_m [NU];
  logic [15:0] err_m  [NU];

  int aw [NU] = '{3, 3, 5};
  int dw [NU] = '{18, 18, 8};
  int pe [NU] = '{0, 1, 0};
  int nf [NU] = '{8, 8, 32};

  int  mgood [NU];
  int  merr  [NU];
  int  err_seen [NU];
  bit  mdone [NU];

  logic [17:0] ram [NU][32];
  wr_t  exp_q[$];
  rec_t tab[$];

  int checks = 0;
  int errors = 0;

  // ---------------- DUTs ----------------
  logic        rw0, dn0, fe0;
  logic [2:0]  a0;
  logic [17:0] d0;
  logic [15:0] g0, e0;
  serial_frame_rx u_dut0 (
    .clk(clk), .rst(rst_n[0]), .sen(sen[0]), .sd(sd[0]),
    .RB2_RW(rw0), .RB2_A(a0), .RB2_D(d0), .RB2_Q(18'h0),
    .S2_done(dn0), .good_cnt(g0), .err_cnt(e0), .frame_err(fe0)
  );

  logic        rw1, dn1, fe1;
  logic [2:0]  a1;
  logic [17:0] d1;
  logic [15:0] g1, e1;
  serial_frame_rx #(.PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .sen(sen[1]), .sd(sd[1]),
    .RB2_RW(rw1), .RB2_A(a1), .RB2_D(d1), .RB2_Q(18'h0),
    .S2_done(dn1), .good_cnt(g1), .err_cnt(e1), .frame_err(fe1)
  );

  logic        rw2, dn2, fe2;
  logic [4:0]  a2;
  logic [7:0]  d2;
  logic [15:0] g2, e2;
  serial_frame_rx #(.ADDR_W(5), .DATA_W(8), .NUM_FRAMES(32)) u_dut2 (
    .clk(clk), .rst(rst_n[2]), .sen(sen[2]), .sd(sd[2]),
    .RB2_RW(rw2), .RB2_A(a2), .RB2_D(d2), .RB2_Q(8'h0),
    .S2_done(dn2), .good_cnt(g2), .err_cnt(e2), .frame_err(fe2)
  );

  assign rw_m[0] = rw0;  assign a_m[0] = {2'b0, a0}; assign d_m[0] = d0;
  assign rw_m[1] = rw1;  assign a_m[1] = {2'b0, a1}; assign d_m[1] = d1;
  assign rw_m[2] = rw2;  assign a_m[2] = a2;         assign d_m[2] = {10'b0, d2};
  assign done_m[0] = dn0; assign ferr_m[0] = fe0; assign good_m[0] = g0; assign err_m[0] = e0;
  assign done_m[1] = dn1; assign ferr_m[1] = fe1; assign good_m[1] = g1; assign err_m[1] = e1;
  assign done_m[2] = dn2; assign ferr_m[2] = fe2; assign good_m[2] = g2; assign err_m[2] = e2;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int flen(input int u);
    return aw[u] + dw[u] + pe[u];
  endfunction

  // Frame bits right-aligned: addr, data, then the even-parity bit if enabled.
  function automatic logic [31:0] mk(input int u, input logic [4:0] a,
                                     input logic [17:0] d, input bit flip);
    logic [31:0] v;
    logic        p;
    v = '0;
    for (int i = aw[u] - 1; i >= 0; i--) v = {v[30:0], a[i]};
    for (int i = dw[u] - 1; i >= 0; i--) v = {v[30:0], d[i]};
    p = (^v) ^ flip;
    if (pe[u] != 0) v = {v[30:0], p};
    return v;
  endfunction

  function automatic rec_t mkrec(input int u, input bit pr, input int nb,
                                 input logic [4:0] a, input logic [17:0] d, input bit flip);
    rec_t r;
    r.u = u; r.pre_rst = pr; r.nbits = nb; r.a = a; r.d = d; r.flip = flip;
    return r;
  endfunction

  task automatic model_clear(input int u);
    mgood[u] = 0; merr[u] = 0; mdone[u] = 1'b0; err_seen[u] = 0;
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_reset(input int u);
    rst_n[u] = 1'b0;
    sen[u]   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rw",   32'(rw_m[u]),   32'd1);
    chk("rst_a",    32'(a_m[u]),    32'd0);
    chk("rst_d",    32'(d_m[u]),    32'd0);
    chk("rst_done", 32'(done_m[u]), 32'd0);
    chk("rst_good", 32'(good_m[u]), 32'd0);
    chk("rst_err",  32'(err_m[u]),  32'd0);
    chk("rst_ferr", 32'(ferr_m[u]), 32'd0);
    rst_n[u] = 1'b1;
    model_clear(u);
    @(negedge clk);
  endtask

  // Send one frame followed by a one-cycle sen=1 gap, then check counters
  // one cycle after the sen-high sample.
  task automatic apply(input rec_t r);
    logic [31:0] v;
    bit good, done_before;
    if (r.pre_rst) do_reset(r.u);
    v = mk(r.u, r.a, r.d, r.flip);
    good = (r.nbits == flen(r.u)) && !r.flip;
    done_before = mdone[r.u];
    for (int i = r.nbits - 1; i >= 0; i--) begin
      sen[r.u] = 1'b0;
      sd[r.u]  = v[i];
      @(negedge clk);
    end
    sen[r.u] = 1'b1;
    sd[r.u]  = 1'b0;
    if (!mdone[r.u]) begin
      if (good) begin
        exp_q.push_back('{u: r.u, a: r.a, d: r.d});
        mgood[r.u]++;
        if (mgood[r.u] == nf[r.u]) mdone[r.u] = 1'b1;
      end else begin
        merr[r.u]++;
      end
    end
    @(negedge clk);
    chk("good_cnt",  32'(good_m[r.u]), 32'(mgood[r.u]));
    chk("err_cnt",   32'(err_m[r.u]),  32'(merr[r.u]));
    chk("ferr_puls", 32'(err_seen[r.u]), 32'(merr[r.u]));
    chk("done_lag",  32'(done_m[r.u]), 32'(done_before));
  endtask

  task automatic run_tab(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) apply(tab[k]);
  endtask

  // ---------------- write / error monitor ----------------
  always @(posedge clk) begin
    wr_t e;
    #1;
    for (int u = 0; u < NU; u++) begin
      if (ferr_m[u] === 1'b1) err_seen[u]++;
      if (rw_m[u] === 1'b0) begin
        chk("err_with_write", 32'(ferr_m[u]), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write_unit", 32'(u), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_unit", 32'(u), 32'(e.u));
          chk("wr_addr", 32'(a_m[u]), 32'(e.a));
          chk("wr_data", 32'(d_m[u]), 32'(e.d));
        end
        ram[u][a_m[u]] = d_m[u];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by 500000, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int u = 0; u < NU; u++) begin
      rst_n[u] = 1'b0; sen[u] = 1'b1; sd[u] = 1'b0;
      model_clear(u);
    end

    // 0-7: eight back-to-back frames, addr n, data 2A5C3+n
    for (int n = 0; n < 8; n++)
      tab.push_back(mkrec(0, n == 0, 21, 5'(n), 18'h2A5C3 + 18'(n), 1'b0));
    // 8-9: 20-bit short frame, then a good one
    tab.push_back(mkrec(0, 1'b1, 20, 5'd1, 18'h0F0F0, 1'b0));
    tab.push_back(mkrec(0, 1'b0, 21, 5'd5, 18'h3FFFF, 1'b0));
    // 10-11: 23-bit over-long frame, then a good one
    tab.push_back(mkrec(0, 1'b0, 23, 5'd1, 18'h12345, 1'b0));
    tab.push_back(mkrec(0, 1'b0, 21, 5'd6, 18'h0ABCD, 1'b0));
    // 12-14: parity unit. addr 2 / data 1 already has an even number of
    // ones, so a parity bit of 1 is the wrong one.
    tab.push_back(mkrec(1, 1'b1, 22, 5'd2, 18'h00001, 1'b1));
    tab.push_back(mkrec(1, 1'b0, 22, 5'd2, 18'h00001, 1'b0));
    tab.push_back(mkrec(1, 1'b0, 22, 5'd7, 18'h15555, 1'b0));

    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) rst_n[u] = 1'b1;
    @(negedge clk);

    // Eight frames; S2_done one cycle after the counter check, i.e. two
    // cycles after the last sen-high sample.
    run_tab(0, 7);
    @(negedge clk);
    chk("t1_done", 32'(done_m[0]), 32'd1);
    chk("t1_rw_idle", 32'(rw_m[0]), 32'd1);
    for (int n = 0; n < 8; n++)
      chk("t1_ram", 32'(ram[0][n]), 32'(18'h2A5C3 + 18'(n)));

    // Short and over-long frames
    run_tab(8, 11);
    chk("t2_ram5", 32'(ram[0][5]), 32'h3FFFF);
    chk("t4_ram6", 32'(ram[0][6]), 32'h0ABCD);

    // Parity
    run_tab(12, 14);
    chk("t3_ram2", 32'(ram[1][2]), 32'h00001);
    chk("t3_err",  32'(err_m[1]),  32'd1);

    // Reset after 10 bits of a frame; the tail bits after release are ignored.
    for (int i = 0; i < 10; i++) begin
      sen[0] = 1'b0; sd[0] = i[0]; @(negedge clk);
    end
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_rw", 32'(rw_m[0]), 32'd1);
    chk("t5_rst_a",  32'(a_m[0]),  32'd0);
    rst_n[0] = 1'b1;
    model_clear(0);
    for (int i = 0; i < 3; i++) begin
      sd[0] = 1'b1; @(negedge clk);
    end
    sen[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_err",  32'(err_m[0]),  32'd0);
    chk("t5_no_good", 32'(good_m[0]), 32'd0);
    for (int n = 0; n < 8; n++)
      apply(mkrec(0, 1'b0, 21, 5'(7 - n), 18'h01000 + 18'(n * 37), 1'b0));
    @(negedge clk);
    chk("t5_done", 32'(done_m[0]), 32'd1);
    chk("t5_err",  32'(err_m[0]),  32'd0);

    // Wide-address unit: addr 7 written twice, 30 others, then a 33rd frame
    apply(mkrec(2, 1'b1, 13, 5'd7, 18'h11, 1'b0));
    apply(mkrec(2, 1'b0, 13, 5'd7, 18'hEE, 1'b0));
    for (int k = 2; k < 32; k++)
      apply(mkrec(2, 1'b0, 13, (k < 9) ? 5'(k - 2) : 5'(k - 1), 18'(8'(k * 3)), 1'b0));
    @(negedge clk);
    chk("t6_done", 32'(done_m[2]), 32'd1);
    apply(mkrec(2, 1'b0, 13, 5'd7, 18'h55, 1'b0));
    chk("t6_ram7", 32'(ram[2][7]), 32'hEE);
    chk("t6_good", 32'(good_m[2]), 32'd32);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
